// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types, half-step coil table and mode-dependent phase decode
package stepper_pkg;
  typedef enum logic [1:0] {MODE_FULL = 2'd0, MODE_WAVE = 2'd1, MODE_HALF = 2'd2, MODE_BYPASS = 2'd3} mode_t;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
  // {a_p, a_m, b_p, b_m} per half-step phase; entry 0 is the rightmost nibble
  localparam logic [7:0][3:0] COIL_TBL = {4'b1001, 4'b0001, 4'b0101, 4'b0100,
                                          4'b0110, 4'b0010, 4'b1010, 4'b1000};
  function automatic logic [3:0] coil_decode(input logic [2:0] phase, input mode_t mode);
    logic [2:0] idx;
    idx = (mode == MODE_HALF) ? phase : (mode == MODE_FULL) ? (phase | 3'd1) : (phase & 3'b110);
    return COIL_TBL[idx];
  endfunction
endpackage

// File: rtl/step_synchronizer.sv
// step_synchronizer: matched multi-flop synchronisers for step/dir plus step rising-edge detect
module step_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_step,
  input  logic i_dir,
  output logic o_step,
  output logic o_dir,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_step_sync, r_dir_sync;
  logic r_step_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_step_sync <= '0;
      r_dir_sync  <= '0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], i_step};
      r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], i_dir};
      r_step_prev <= r_step_sync[SYNC_STAGES-1];
    end
  assign o_step = r_step_sync[SYNC_STAGES-1];
  assign o_dir  = r_dir_sync[SYNC_STAGES-1];
  assign o_rise = o_step & ~r_step_prev;
endmodule

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: step/dir or internal move engine driving a bipolar stepper's H-bridge enables
module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int POS_W       = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             ext_sel,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic             move_start,
  input  logic             move_abort,
  input  logic [POS_W-1:0] move_target,
  input  logic [DIV_W-1:0] move_period,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             coil_a_p,
  output logic             coil_a_m,
  output logic             coil_b_p,
  output logic             coil_b_m
);
  state_t r_state, w_next;
  mode_t w_mode;
  logic [POS_W-1:0] r_pos, r_target, w_diff, w_pos_next;
  logic [DIV_W-1:0] r_period, r_cnt, w_period;
  logic [2:0] r_phase, w_stride;
  logic [3:0] w_coil;
  logic r_dir, r_done, w_done, w_step_s, w_dir_s, w_rise, w_run, w_tc, w_kill, w_step, w_dir, w_pulse;
  step_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_step(step_i),
    .i_dir (dir_i),
    .o_step(w_step_s),
    .o_dir (w_dir_s),
    .o_rise(w_rise)
  );
  assign w_mode     = mode_t'(mode);
  assign w_run      = r_state == S_RUN;
  assign w_period   = (move_period < DIV_W'(2)) ? DIV_W'(2) : move_period;
  assign w_diff     = move_target - r_pos;
  assign w_tc       = w_run && (r_cnt == r_period - DIV_W'(1));
  assign w_kill     = move_abort | ~enable | ext_sel;
  assign w_dir      = ext_sel ? w_dir_s : r_dir;
  // abort/disable/source switch wins over a coincident terminal count
  assign w_step     = enable & (ext_sel ? w_rise : (w_tc & ~w_kill));
  assign w_pos_next = w_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
  assign w_stride   = (w_mode == MODE_HALF) ? 3'd1 : 3'd2;
  assign w_pulse    = ext_sel ? w_step_s : (w_run && (r_cnt < (r_period >> 1)));
  assign w_coil     = !enable ? 4'b0000 :
                      (w_mode == MODE_BYPASS) ? {w_dir, 1'b0, w_pulse, 1'b0} : coil_decode(r_phase, w_mode);
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    if (!w_run) begin
      if (move_start && !ext_sel && enable) begin
        w_next = (w_diff == '0) ? S_IDLE : S_RUN;
        w_done = w_diff == '0;
      end
    end else if (w_kill) begin
      w_next = S_IDLE;
    end else if (w_tc && (w_pos_next == r_target)) begin
      w_next = S_IDLE;
      w_done = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_target <= '0;
      r_dir    <= 1'b0;
      r_pos    <= '0;
      r_phase  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      r_cnt   <= (w_run && !w_tc) ? r_cnt + DIV_W'(1) : '0;
      if (!w_run && w_next == S_RUN) begin
        r_target <= move_target;
        r_period <= w_period;
        r_dir    <= ~w_diff[POS_W-1];
      end
      if (w_step) begin
        r_pos   <= w_pos_next;
        r_phase <= w_dir ? r_phase + w_stride : r_phase - w_stride;
      end
    end
  assign position = r_pos;
  assign busy     = w_run;
  assign done     = r_done;
  assign {coil_a_p, coil_a_m, coil_b_p, coil_b_m} = w_coil;
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: randomized self-checking bench against a phase/position reference model
module tb_stepper_sequencer;
  localparam int SYNC = 2;
  logic clk = 0, rst_n = 0, enable = 0, ext_sel = 0, step_i = 0, dir_i = 0;
  logic move_start = 0, move_abort = 0;
  logic [1:0] mode = 2'd2;
  logic [15:0] move_target = 0, move_period = 0;
  logic [15:0] position;
  logic busy, done, coil_a_p, coil_a_m, coil_b_p, coil_b_m;
  wire [3:0] coils = {coil_a_p, coil_a_m, coil_b_p, coil_b_m};
  int n_chk = 0, n_fail = 0, done_seen = 0;
  int m_pos = 0, m_phase = 0;
  int sa[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int sb[8] = '{0, 1, 1, 1, 0, -1, -1, -1};

  stepper_sequencer #(.POS_W(16), .DIV_W(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .ext_sel(ext_sel),
    .step_i(step_i), .dir_i(dir_i), .move_start(move_start), .move_abort(move_abort),
    .move_target(move_target), .move_period(move_period), .position(position),
    .busy(busy), .done(done), .coil_a_p(coil_a_p), .coil_a_m(coil_a_m),
    .coil_b_p(coil_b_p), .coil_b_m(coil_b_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) done_seen++;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [3:0] exp_coils(int ph, int md, logic en);
    int i;
    if (!en) return 4'b0000;
    i = (md == 2) ? ph : (md == 0) ? (ph | 1) : (ph & 6);
    return {sa[i] == 1, sa[i] == -1, sb[i] == 1, sb[i] == -1};
  endfunction

  task automatic model_step(int dir, int md);
    m_pos   = (m_pos + (dir != 0 ? 1 : -1)) & 16'hFFFF;
    m_phase = (m_phase + (md == 2 ? 1 : 2) * (dir != 0 ? 1 : -1)) & 7;
  endtask

  task automatic do_reset;
    rst_n = 0; enable = 1; ext_sel = 0; step_i = 0; dir_i = 0;
    move_start = 0; move_abort = 0; mode = 2'd2;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_pos = 0; m_phase = 0;
    @(negedge clk);
  endtask

  task automatic ext_pulse(output logic [15:0] pre, output logic [15:0] post);
    step_i = 1;
    repeat (SYNC) @(posedge clk);
    @(negedge clk) pre = position;
    @(negedge clk) post = position;
    step_i = 0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset;
    n_chk++; if (position !== 16'd0) begin n_fail++; $display("FAIL reset_pos: got %h want 0000", position); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    for (int md = 0; md < 3; md++) begin
      mode = 2'(md);
      #1;
      n_chk++;
      if (coils !== exp_coils(0, md, 1'b1)) begin
        n_fail++; $display("FAIL reset_coils mode %0d: got %b want %b", md, coils, exp_coils(0, md, 1'b1));
      end
    end
    enable = 0;
    #1;
    n_chk++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL reset_disabled_coils: got %b want 0000", coils); end
    enable = 1;
  endtask

  task automatic test_ext_half;
    logic [15:0] pre, post;
    do_reset;
    ext_sel = 1; mode = 2'd2; dir_i = 1;
    repeat (SYNC + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ext_pulse(pre, post);
      n_chk++; if (pre !== 16'(m_pos)) begin n_fail++; $display("FAIL half_latency %0d: got %h want %h", i, pre, 16'(m_pos)); end
      model_step(1, 2);
      n_chk++; if (post !== 16'(m_pos)) begin n_fail++; $display("FAIL half_pos %0d: got %h want %h", i, post, 16'(m_pos)); end
      n_chk++; if (coils !== exp_coils(m_phase, 2, 1'b1)) begin
        n_fail++; $display("FAIL half_coils %0d: got %b want %b", i, coils, exp_coils(m_phase, 2, 1'b1));
      end
    end
    n_chk++; if (position !== 16'd8) begin n_fail++; $display("FAIL half_final_pos: got %h want 0008", position); end
  endtask

  task automatic test_ext_full;
    logic [15:0] pre, post;
    logic [3:0] seq [4] = '{4'b1001, 4'b0101, 4'b0110, 4'b1010};
    do_reset;
    ext_sel = 1; mode = 2'd0; dir_i = 0;
    repeat (SYNC + 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ext_pulse(pre, post);
      model_step(0, 0);
      n_chk++; if (coils !== seq[i]) begin n_fail++; $display("FAIL full_coils %0d: got %b want %b", i, coils, seq[i]); end
    end
    n_chk++; if (position !== 16'hFFFC) begin n_fail++; $display("FAIL full_final_pos: got %h want fffc", position); end
  endtask

  task automatic test_ext_random;
    logic [15:0] pre, post;
    int md, dr;
    ext_sel = 1;
    for (int i = 0; i < 14; i++) begin
      md = $urandom_range(0, 2);
      dr = $urandom_range(0, 1);
      mode = 2'(md); dir_i = dr[0];
      enable = ($urandom_range(0, 4) != 0);
      repeat (SYNC + 2) @(negedge clk);
      ext_pulse(pre, post);
      if (enable) model_step(dr, md);
      n_chk++; if (post !== 16'(m_pos)) begin n_fail++; $display("FAIL rand_pos %0d: got %h want %h", i, post, 16'(m_pos)); end
      n_chk++; if (coils !== exp_coils(m_phase, md, enable)) begin
        n_fail++; $display("FAIL rand_coils %0d: got %b want %b", i, coils, exp_coils(m_phase, md, enable));
      end
    end
    enable = 1; ext_sel = 0;
    ext_pulse(pre, post);
    n_chk++; if (post !== 16'(m_pos)) begin n_fail++; $display("FAIL ext_ignored: got %h want %h", post, 16'(m_pos)); end
  endtask

  task automatic test_internal;
    int delta, per, eff, dir, steps;
    do_reset;
    for (int m = 0; m < 4; m++) begin
      delta = (m == 0) ? 5 : int'($urandom_range(1, 6)) * (($urandom_range(0, 1) != 0) ? 1 : -1);
      per   = (m == 0) ? 10 : $urandom_range(0, 12);
      mode  = (m == 0) ? 2'd2 : 2'($urandom_range(0, 2));
      eff   = (per < 2) ? 2 : per;
      dir   = (delta > 0) ? 1 : 0;
      steps = (delta > 0) ? delta : -delta;
      move_target = 16'(m_pos + delta);
      move_period = 16'(per);
      done_seen = 0;
      move_start = 1;
      @(negedge clk) move_start = 0;
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL int_busy_start %0d: got %b want 1", m, busy); end
      for (int k = 1; k <= steps; k++) begin
        repeat (eff - 1) @(negedge clk);
        n_chk++; if (position !== 16'(m_pos)) begin n_fail++; $display("FAIL int_early %0d/%0d: got %h want %h", m, k, position, 16'(m_pos)); end
        @(negedge clk);
        model_step(dir, int'(mode));
        n_chk++; if (position !== 16'(m_pos)) begin n_fail++; $display("FAIL int_pos %0d/%0d: got %h want %h", m, k, position, 16'(m_pos)); end
        n_chk++; if (coils !== exp_coils(m_phase, int'(mode), 1'b1)) begin
          n_fail++; $display("FAIL int_coils %0d/%0d: got %b want %b", m, k, coils, exp_coils(m_phase, int'(mode), 1'b1));
        end
        n_chk++; if (busy !== (k < steps)) begin n_fail++; $display("FAIL int_busy %0d/%0d: got %b want %b", m, k, busy, k < steps); end
        n_chk++; if (done !== (k == steps)) begin n_fail++; $display("FAIL int_done %0d/%0d: got %b want %b", m, k, done, k == steps); end
      end
      @(negedge clk);
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL int_done_width %0d: got %b want 0", m, done); end
      n_chk++; if (done_seen != 1) begin n_fail++; $display("FAIL int_done_count %0d: got %0d want 1", m, done_seen); end
    end
  endtask

  task automatic test_zero_abort;
    move_target = 16'(m_pos);
    move_period = 16'd5;
    done_seen = 0;
    move_start = 1;
    @(negedge clk) move_start = 0;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b want 0", busy); end
    @(negedge clk);
    n_chk++; if (done_seen != 1 || done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got count %0d done %b want 1 0", done_seen, done); end
    mode = 2'd2;
    move_target = 16'(m_pos + 6);
    move_period = 16'd4;
    done_seen = 0;
    move_start = 1;
    @(negedge clk) move_start = 0;
    for (int k = 0; k < 2; k++) begin
      repeat (4) @(negedge clk);
      model_step(1, 2);
    end
    repeat (3) @(negedge clk);
    move_abort = 1;
    @(negedge clk) move_abort = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_chk++; if (position !== 16'(m_pos)) begin n_fail++; $display("FAIL abort_pos: got %h want %h", position, 16'(m_pos)); end
    repeat (40) @(negedge clk);
    n_chk++; if (position !== 16'(m_pos)) begin n_fail++; $display("FAIL abort_hold: got %h want %h", position, 16'(m_pos)); end
    n_chk++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_seen); end
  endtask

  task automatic test_bypass;
    int hi;
    mode = 2'd3; enable = 1; ext_sel = 0;
    move_target = 16'(m_pos + 3);
    move_period = 16'd8;
    done_seen = 0; hi = 0;
    move_start = 1;
    @(negedge clk) move_start = 0;
    for (int i = 0; i < 8; i++) begin
      if (coil_b_p === 1'b1) hi++;
      n_chk++; if ({coil_a_p, coil_a_m, coil_b_m} !== 3'b100) begin
        n_fail++; $display("FAIL byp_static %0d: got a_p/a_m/b_m %b want 100", i, {coil_a_p, coil_a_m, coil_b_m});
      end
      @(negedge clk);
    end
    n_chk++; if (hi != 4) begin n_fail++; $display("FAIL byp_duty: got %0d want 4", hi); end
    model_step(1, 3);
    repeat (16) @(negedge clk);
    model_step(1, 3); model_step(1, 3);
    n_chk++; if (position !== 16'(m_pos) || done_seen != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL byp_move: got pos %h done %0d busy %b want %h 1 0", position, done_seen, busy, 16'(m_pos));
    end
    enable = 0;
    #1;
    n_chk++; if (coils !== 4'b0000) begin n_fail++; $display("FAIL byp_disabled: got %b want 0000", coils); end
    enable = 1; mode = 2'd2;
    move_target = 16'(m_pos + 4);
    move_period = 16'd5;
    done_seen = 0;
    move_start = 1;
    @(negedge clk) move_start = 0;
    repeat (5) @(negedge clk);
    model_step(1, 2);
    enable = 0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || coils !== 4'b0000) begin n_fail++; $display("FAIL dis_abort: got busy %b coils %b want 0 0000", busy, coils); end
    repeat (20) @(negedge clk);
    n_chk++; if (position !== 16'(m_pos) || done_seen != 0) begin
      n_fail++; $display("FAIL dis_hold: got pos %h done %0d want %h 0", position, done_seen, 16'(m_pos));
    end
    enable = 1; ext_sel = 1; mode = 2'd3; dir_i = 1;
    repeat (SYNC + 1) @(negedge clk);
    step_i = 1;
    repeat (SYNC) @(posedge clk);
    @(negedge clk);
    n_chk++; if (coils !== 4'b1010) begin n_fail++; $display("FAIL byp_ext: got %b want 1010", coils); end
    model_step(1, 3);
    step_i = 0;
    repeat (SYNC + 3) @(negedge clk);
    n_chk++; if (position !== 16'(m_pos)) begin n_fail++; $display("FAIL byp_ext_pos: got %h want %h", position, 16'(m_pos)); end
    ext_sel = 0;
  endtask

  task automatic test_reset_mid;
    mode = 2'd2; enable = 1; ext_sel = 0;
    move_target = 16'(m_pos + 5);
    move_period = 16'd10;
    move_start = 1;
    @(negedge clk) move_start = 0;
    repeat (13) @(negedge clk);
    #2 rst_n = 0;
    #1;
    m_pos = 0; m_phase = 0;
    n_chk++; if (position !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state: got pos %h busy %b done %b want 0000 0 0", position, busy, done);
    end
    n_chk++; if (coils !== exp_coils(0, 2, 1'b1)) begin n_fail++; $display("FAIL rst_mid_coils: got %b want %b", coils, exp_coils(0, 2, 1'b1)); end
    @(negedge clk) rst_n = 1;
    done_seen = 0;
    repeat (80) @(negedge clk);
    n_chk++; if (done_seen != 0 || busy !== 1'b0 || position !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid_after: got done %0d busy %b pos %h want 0 0 0000", done_seen, busy, position);
    end
  endtask

  initial begin
    test_reset;
    test_ext_half;
    test_ext_full;
    test_ext_random;
    test_internal;
    test_zero_abort;
    test_bypass;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
